approx_error_sweeper: RTL
=========================

// Module: approx_error_sweeper
// PURPOSE
//  Exhaustive error-evaluation stage for generated approximate circuits. It drives every
//  input vector 0..2^IN_W-1 into a combinational approximate circuit and its exact
//  counterpart in parallel, for example an abs_diff SOP/shared-logic candidate.
//  It computes the error |exact - approx| for each vector and reports max error, summed
//  error and the count of vectors over the error threshold ET. The result is a pass flag
//  that signals the candidate meets ET.
// PARAMETERS
//  IN_W   4  width of the stimulus vector (bit i drives candidate input in<i>)
//  OUT_W  3  width of candidate/exact outputs, unsigned, bit 0 = out0
//  ET     4  error threshold; a vector violates when err > ET
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              synchronous, active-high reset
//  start        in   1              request a sweep; honoured only in IDLE
//  stim         out  IN_W           registered stimulus to both circuits
//  exact_in     in   OUT_W          exact circuit output for current stim (combinational)
//  approx_in    in   OUT_W          approximate circuit output for current stim
//  busy         out  1              high from the edge accepting start until done
//  done         out  1              one-cycle pulse when results are final
//  max_err      out  OUT_W          largest |exact-approx| seen in the sweep
//  sum_err      out  OUT_W+IN_W     sum of all errors; cannot overflow
//  viol_count   out  IN_W+1         number of vectors with err > ET
//  pass         out  1              viol_count==0; updated with done
// BEHAVIOUR
//  - Reset values: stim=0, busy=0, done=0, max_err=0, sum_err=0, viol_count=0, pass=0,
//    state=IDLE, err_v=0.
//  - FSM states: IDLE, SWEEP, DRAIN, DONE.
//  - IDLE: if start at edge E0 -> SWEEP; stim<=0, busy<=1.
//    The same edge clears max_err, sum_err and viol_count.
//  - SWEEP: each edge registers err_q<=|exact_in-approx_in| for the current stim.
//    The subtraction is done at OUT_W+1 bits and the absolute value taken.
//    The same edge sets err_v<=1 and increments stim.
//    At the edge where stim==2^IN_W-1, stim holds and the FSM goes to DRAIN (no wrap to 0).
//  - Accumulate on every edge with err_v=1:
//    max_err<=max(max_err,err_q); sum_err+=err_q; viol_count+=(err_q>ET).
//  - DRAIN: one edge; it accumulates the last err_q, sets err_v<=0 and moves to DONE.
//    The same edge sets done<=1 and pass<=(final viol_count==0).
//  - DONE: one cycle with done=1 and busy=0, then IDLE.
//    Results hold until the next accepted start.
//  - Latency: start accepted at E0; vectors captured at E1..E(2^IN_W).
//    done is high during the cycle after E(2^IN_W+1), i.e. 17 edges after E0 for IN_W=4.
//  - start while busy or DONE is ignored, with no restart and no effect on the results.
//  - start held high continuously: a new sweep is accepted in the first IDLE cycle after
//    done.
//  - rst mid-sweep returns all outputs to reset values; no done pulse is produced.
//  - exact_in and approx_in are sampled only in SWEEP; X or changing values in other
//    states are ignored.
// TESTING
//  1 Loopback (approx_in=exact_in=any function of stim), start pulse -> done at E0+17;
//    max_err=0, sum_err=0, viol_count=0, pass=1.
//  2 approx_in=exact_in^3'b100 for all stim -> max_err=4, sum_err=64, viol_count=0, pass=1
//    (err==ET is not a violation).
//  3 approx_in=0; exact_in=7 only when stim==5, else 0 -> max_err=7, sum_err=7,
//    viol_count=1, pass=0.
//  4 approx_in=0; exact_in=7 only when stim==15 (last vector) -> max_err=7, viol_count=1,
//    which exercises the DRAIN accumulation; stim never wraps to 0 before done.
//  5 start pulsed again at E0+5 -> ignored: a single done at E0+17 with unchanged results.
//    Then start in the cycle after done -> accumulators cleared and a new sweep begins.
//  6 rst asserted at E0+8 -> next cycle busy=0, stim=0, all results 0, pass=0.
//    No done pulse follows; a subsequent start completes normally.

Source files
------------

// File: rtl/approx_error_sweeper.sv
// Exhaustive error sweeper: drives every stimulus vector into an exact/approximate circuit
// pair and accumulates max error, summed error and the threshold-violation count.
module approx_error_sweeper #(
   parameter int IN_W  = 4,
   parameter int OUT_W = 3,
   parameter int ET    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [IN_W-1:0]       stim,
   input  logic [OUT_W-1:0]      exact_in,
   input  logic [OUT_W-1:0]      approx_in,
   output logic                  busy,
   output logic                  done,
   output logic [OUT_W-1:0]      max_err,
   output logic [OUT_W+IN_W-1:0] sum_err,
   output logic [IN_W:0]         viol_count,
   output logic                  pass
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SWEEP = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [IN_W-1:0] STIM_LAST = '1;

   logic [1:0]            state_q, state_d;
   logic [IN_W-1:0]       stim_q, stim_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [OUT_W-1:0]      max_err_q, max_err_d;
   logic [OUT_W+IN_W-1:0] sum_err_q, sum_err_d;
   logic [IN_W:0]         viol_count_q, viol_count_d;
   logic                  pass_q, pass_d;
   logic [OUT_W-1:0]      err_q, err_d;
   logic                  err_v_q, err_v_d;

   logic [OUT_W:0]        diff;
   logic [OUT_W:0]        diff_neg;
   logic [OUT_W-1:0]      abs_err;
   logic [OUT_W-1:0]      max_acc;
   logic [OUT_W+IN_W-1:0] sum_acc;
   logic [IN_W:0]         viol_acc;

   // The subtraction carries one extra bit so its sign tells which operand was larger.
   always_comb begin
      diff     = {1'b0, exact_in} - {1'b0, approx_in};
      diff_neg = -diff;
      abs_err  = diff[OUT_W] ? diff_neg[OUT_W-1:0] : diff[OUT_W-1:0];
   end

   always_comb begin
      max_acc  = max_err_q;
      sum_acc  = sum_err_q;
      viol_acc = viol_count_q;
      if (err_v_q) begin
         max_acc = (err_q > max_err_q) ? err_q : max_err_q;
         sum_acc = sum_err_q + {{IN_W{1'b0}}, err_q};
         if (int'(err_q) > ET) viol_acc = viol_count_q + (IN_W+1)'(1);
      end
   end

   always_comb begin
      // NOTE: every _d starts from its held value so no path through the case infers a latch.
      state_d      = state_q;
      stim_d       = stim_q;
      busy_d       = busy_q;
      done_d       = done_q;
      max_err_d    = max_acc;
      sum_err_d    = sum_acc;
      viol_count_d = viol_acc;
      pass_d       = pass_q;
      err_d        = err_q;
      err_v_d      = err_v_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_SWEEP;
               stim_d       = '0;
               busy_d       = 1'b1;
               max_err_d    = '0;
               sum_err_d    = '0;
               viol_count_d = '0;
            end
         end
         ST_SWEEP: begin
            err_d   = abs_err;
            err_v_d = 1'b1;
            if (stim_q == STIM_LAST) state_d = ST_DRAIN;
            else                     stim_d  = stim_q + IN_W'(1);
         end
         ST_DRAIN: begin
            err_v_d = 1'b0;
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            pass_d  = (viol_acc == '0);
         end
         default: begin
            done_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         stim_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         max_err_q    <= '0;
         sum_err_q    <= '0;
         viol_count_q <= '0;
         pass_q       <= 1'b0;
         err_q        <= '0;
         err_v_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         stim_q       <= stim_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         max_err_q    <= max_err_d;
         sum_err_q    <= sum_err_d;
         viol_count_q <= viol_count_d;
         pass_q       <= pass_d;
         err_q        <= err_d;
         err_v_q      <= err_v_d;
      end
   end

   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign max_err    = max_err_q;
   assign sum_err    = sum_err_q;
   assign viol_count = viol_count_q;
   assign pass       = pass_q;

endmodule
